// File: rtl/tetris_board_avl_writer.sv
// Avalon-MM master that keeps the game-side shadow of the 20x10 Tetris board
// and writes dirty rows (or every row on a full refresh) into VGA VRAM, one word per row.
module tetris_board_avl_writer #(
    parameter int          NUM_ROWS  = 20,
    parameter int          ROW_BITS  = 10,
    parameter logic [11:0] BASE_ADDR = 12'h000
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                ROW_WE,
    input  logic [4:0]          ROW_IDX,
    input  logic [ROW_BITS-1:0] ROW_DATA,
    input  logic                COMMIT,
    input  logic                FULL_REFRESH,
    output logic                BUSY,
    output logic                DONE,
    output logic                AVM_CS,
    output logic                AVM_WRITE,
    output logic [11:0]         AVM_ADDR,
    output logic [3:0]          AVM_BYTE_EN,
    output logic [31:0]         AVM_WRITEDATA,
    input  logic                AVM_WAITREQUEST
);
    localparam logic [4:0] LAST_IDX = 5'(NUM_ROWS);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WRITE, S_FINISH} state_e;

    state_e              state_q, state_d;
    logic [ROW_BITS-1:0] shadow_q [NUM_ROWS];
    logic [ROW_BITS-1:0] shadow_d [NUM_ROWS];
    logic [ROW_BITS-1:0] snap_q   [NUM_ROWS];
    logic [ROW_BITS-1:0] snap_d   [NUM_ROWS];
    logic [NUM_ROWS-1:0] dirty_q, dirty_d;
    logic [NUM_ROWS-1:0] work_q, work_d;
    logic                pending_q, pending_d;
    logic                full_q, full_d;
    logic [4:0]          idx_q, idx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                cs_q, cs_d;
    logic                wr_q, wr_d;
    logic [11:0]         addr_q, addr_d;
    logic [3:0]          be_q, be_d;
    logic [31:0]         wdata_q, wdata_d;

    logic row_ok;
    logic start;
    logic scan_end;

    assign row_ok   = ROW_WE && (ROW_IDX < LAST_IDX);
    // A COMMIT arriving while idle is taken the same cycle it is seen.
    assign start    = (state_q == S_IDLE) && (pending_q || COMMIT);
    assign scan_end = (idx_q == LAST_IDX);

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            for (int r = 0; r < NUM_ROWS; r++) begin
                shadow_q[r] <= '0;
                snap_q[r]   <= '0;
            end
            dirty_q   <= '1;
            work_q    <= '0;
            pending_q <= 1'b0;
            full_q    <= 1'b0;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cs_q      <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            snap_q    <= snap_d;
            dirty_q   <= dirty_d;
            work_q    <= work_d;
            pending_q <= pending_d;
            full_q    <= full_d;
            idx_q     <= idx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cs_q      <= cs_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_SCAN;
            S_SCAN: begin
                if (scan_end)             state_d = S_FINISH;
                else if (work_q[idx_q])   state_d = S_WRITE;
            end
            S_WRITE:  if (!AVM_WAITREQUEST) state_d = S_SCAN;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        shadow_d  = shadow_q;
        snap_d    = snap_q;
        dirty_d   = dirty_q;
        work_d    = work_q;
        pending_d = pending_q | COMMIT;
        full_d    = full_q | (COMMIT & FULL_REFRESH);
        idx_d     = idx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cs_d      = cs_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    snap_d    = shadow_q;
                    work_d    = (full_q | (COMMIT & FULL_REFRESH)) ? '1 : dirty_q;
                    dirty_d   = '0;
                    pending_d = 1'b0;
                    full_d    = 1'b0;
                    idx_d     = '0;
                    busy_d    = 1'b1;
                end
            end
            S_SCAN: begin
                if (!scan_end) begin
                    if (work_q[idx_q]) begin
                        cs_d    = 1'b1;
                        wr_d    = 1'b1;
                        addr_d  = BASE_ADDR + {7'd0, idx_q};
                        be_d    = 4'hF;
                        wdata_d = {{(32-ROW_BITS){1'b0}}, snap_q[idx_q]};
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            S_WRITE: begin
                if (!AVM_WAITREQUEST) begin
                    cs_d    = 1'b0;
                    wr_d    = 1'b0;
                    addr_d  = '0;
                    be_d    = '0;
                    wdata_d = '0;
                    idx_d   = idx_q + 5'd1;
                end
            end
            S_FINISH: begin
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            default: ;
        endcase
        // Applied last so a same-cycle row write survives the dirty clear at capture.
        if (row_ok) begin
            shadow_d[ROW_IDX] = ROW_DATA;
            dirty_d[ROW_IDX]  = 1'b1;
        end
    end

    assign BUSY          = busy_q;
    assign DONE          = done_q;
    assign AVM_CS        = cs_q;
    assign AVM_WRITE     = wr_q;
    assign AVM_ADDR      = addr_q;
    assign AVM_BYTE_EN   = be_q;
    assign AVM_WRITEDATA = wdata_q;

endmodule

// File: tb/tb_tetris_board_avl_writer.sv
// Bench for tetris_board_avl_writer: board-level reference model feeding an
// expected-write queue, with an independent bus monitor popping and comparing.
module tb_tetris_board_avl_writer;
  localparam int NR = 20;
  localparam logic [11:0] BASE = 12'h000;

  logic        clk = 1'b0;
  logic        RESET_N;
  logic        ROW_WE;
  logic [4:0]  ROW_IDX;
  logic [9:0]  ROW_DATA;
  logic        COMMIT;
  logic        FULL_REFRESH;
  logic        BUSY;
  logic        DONE;
  logic        AVM_CS;
  logic        AVM_WRITE;
  logic [11:0] AVM_ADDR;
  logic [3:0]  AVM_BYTE_EN;
  logic [31:0] AVM_WRITEDATA;
  logic        AVM_WAITREQUEST;

  always #10 clk = ~clk;

  tetris_board_avl_writer #(.NUM_ROWS(NR), .ROW_BITS(10), .BASE_ADDR(BASE)) dut (
    .CLK(clk), .RESET_N(RESET_N), .ROW_WE(ROW_WE), .ROW_IDX(ROW_IDX), .ROW_DATA(ROW_DATA),
    .COMMIT(COMMIT), .FULL_REFRESH(FULL_REFRESH), .BUSY(BUSY), .DONE(DONE),
    .AVM_CS(AVM_CS), .AVM_WRITE(AVM_WRITE), .AVM_ADDR(AVM_ADDR), .AVM_BYTE_EN(AVM_BYTE_EN),
    .AVM_WRITEDATA(AVM_WRITEDATA), .AVM_WAITREQUEST(AVM_WAITREQUEST)
  );

  int checks = 0;
  int failures = 0;

  logic [43:0] exp_q[$];
  int          hold_q[$];
  int          done_cnt = 0;
  int          acc_cnt = 0;
  int          exp_done = 0;
  int          stall_left = 0;
  bit          rand_wait = 1'b0;

  logic [9:0]  m_shadow [NR];
  bit          m_dirty [NR];
  bit          m_pending, m_full, m_busy;

  function automatic void check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  function automatic void model_reset();
    for (int r = 0; r < NR; r++) begin
      m_shadow[r] = '0;
      m_dirty[r]  = 1'b1;
    end
    m_pending = 1'b0;
    m_full    = 1'b0;
    m_busy    = 1'b0;
    exp_q.delete();
    exp_done = done_cnt;
  endfunction

  function automatic void model_capture();
    for (int r = 0; r < NR; r++) begin
      if (m_full || m_dirty[r])
        exp_q.push_back({BASE + 12'(r), {22'd0, m_shadow[r]}});
      m_dirty[r] = 1'b0;
    end
    m_full    = 1'b0;
    m_pending = 1'b0;
    m_busy    = 1'b1;
    exp_done++;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic row_write(input logic [4:0] idx, input logic [9:0] data);
    ROW_WE = 1'b1; ROW_IDX = idx; ROW_DATA = data;
    tick();
    ROW_WE = 1'b0;
    if (int'(idx) < NR) begin
      m_shadow[idx] = data;
      m_dirty[idx]  = 1'b1;
    end
  endtask

  task automatic commit(input bit full);
    COMMIT = 1'b1; FULL_REFRESH = full;
    tick();
    COMMIT = 1'b0; FULL_REFRESH = 1'b0;
    if (m_busy) begin
      m_pending = 1'b1;
      m_full    = m_full | full;
    end else begin
      m_full = full;
      model_capture();
    end
  endtask

  task automatic wait_done(input string name);
    int budget;
    forever begin
      budget = 0;
      while (done_cnt < exp_done && budget < 3000) begin
        tick();
        budget++;
      end
      if (done_cnt < exp_done) begin
        check(1'b0, {name, "_done_timeout"}, done_cnt, exp_done);
        done_cnt = exp_done;
        exp_q.delete();
      end
      if (!m_pending) break;
      model_capture();
    end
    m_busy = 1'b0;
    tick();
    tick();
    check(exp_q.size() == 0, {name, "_all_writes_seen"}, exp_q.size(), 0);
    check(done_cnt == exp_done, {name, "_done_count"}, done_cnt, exp_done);
  endtask

  // ---------------- slave stall generator ----------------
  initial begin
    AVM_WAITREQUEST = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (AVM_WRITE && stall_left > 0) begin
        AVM_WAITREQUEST = 1'b1;
        stall_left--;
      end else begin
        AVM_WAITREQUEST = rand_wait ? ($urandom_range(0, 2) == 0) : 1'b0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [43:0] mon_e;
  logic [11:0] p_addr;
  logic [31:0] p_data;
  bit          p_hold = 1'b0;
  int          hold_cnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (RESET_N !== 1'b1) begin
        p_hold = 1'b0;
        hold_cnt = 0;
        continue;
      end
      check(AVM_CS == AVM_WRITE, "cs_follows_write", AVM_CS, AVM_WRITE);
      if (DONE) begin
        done_cnt++;
        check(!BUSY, "busy_low_with_done", BUSY, 0);
      end
      if (p_hold)
        check(AVM_WRITE && AVM_ADDR == p_addr && AVM_WRITEDATA == p_data,
              "stalled_write_stable", {AVM_WRITE, AVM_ADDR, AVM_WRITEDATA}, {1'b1, p_addr, p_data});
      if (!AVM_WRITE)
        check(AVM_ADDR == 0 && AVM_WRITEDATA == 0 && AVM_BYTE_EN == 0,
              "idle_bus_zero", {AVM_ADDR, AVM_WRITEDATA, AVM_BYTE_EN}, 0);
      if (AVM_WRITE) begin
        hold_cnt++;
        if (!AVM_WAITREQUEST) begin
          acc_cnt++;
          hold_q.push_back(hold_cnt);
          hold_cnt = 0;
          check(AVM_BYTE_EN == 4'hF, "byte_enable", AVM_BYTE_EN, 4'hF);
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_write", {AVM_ADDR, AVM_WRITEDATA}, 0);
          end else begin
            mon_e = exp_q.pop_front();
            check({AVM_ADDR, AVM_WRITEDATA} == mon_e, "write_addr_data", {AVM_ADDR, AVM_WRITEDATA}, mon_e);
          end
        end
      end
      p_hold = AVM_WRITE && AVM_WAITREQUEST;
      p_addr = AVM_ADDR;
      p_data = AVM_WRITEDATA;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int a0, d0, lat, b, n;
    RESET_N = 1'b0; ROW_WE = 1'b0; ROW_IDX = '0; ROW_DATA = '0;
    COMMIT = 1'b0; FULL_REFRESH = 1'b0;
    repeat (3) tick();
    tick();
    RESET_N = 1'b1;
    model_reset();
    @(negedge clk);
    check(BUSY == 0 && DONE == 0, "reset_busy_done", {BUSY, DONE}, 0);
    check(AVM_CS == 0 && AVM_WRITE == 0, "reset_cs_write", {AVM_CS, AVM_WRITE}, 0);
    check(AVM_ADDR == 0 && AVM_WRITEDATA == 0 && AVM_BYTE_EN == 0, "reset_bus", {AVM_ADDR, AVM_WRITEDATA, AVM_BYTE_EN}, 0);
    tick();

    // first commit after reset paints all rows; measure latency to first write
    a0 = acc_cnt;
    commit(1'b0);
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) check(BUSY == 1'b1, "busy_after_commit", BUSY, 1);
      if (AVM_WRITE && lat < 0) lat = k;
    end
    check(lat == 2, "first_write_latency", lat, 2);
    tick();
    wait_done("t1");
    check(acc_cnt - a0 == 20, "t1_write_count", acc_cnt - a0, 20);

    // two dirty rows, sent in row order
    row_write(5'd19, 10'h3FF);
    row_write(5'd5, 10'h201);
    a0 = acc_cnt;
    commit(1'b0);
    wait_done("t2");
    check(acc_cnt - a0 == 2, "t2_write_count", acc_cnt - a0, 2);

    // four wait states on the first write
    row_write(5'd7, 10'h155);
    row_write(5'd8, 10'h0AA);
    hold_q.delete();
    stall_left = 4;
    commit(1'b0);
    wait_done("t3");
    check(hold_q.size() >= 1 && hold_q[0] == 5, "t3_stall_cycles", (hold_q.size() >= 1) ? hold_q[0] : -1, 5);

    // commit during busy merges a later row write into a second transfer
    for (int r = 0; r < 10; r++) row_write(5'(r), 10'($urandom_range(0, 1023)));
    d0 = done_cnt;
    a0 = acc_cnt;
    commit(1'b0);
    repeat (3) tick();
    row_write(5'd5, 10'h0FF);
    commit(1'b0);
    commit(1'b0);
    wait_done("t4");
    check(done_cnt - d0 == 2, "t4_done_pulses", done_cnt - d0, 2);
    check(acc_cnt - a0 == 11, "t4_write_count", acc_cnt - a0, 11);

    // full refresh with nothing dirty
    a0 = acc_cnt;
    commit(1'b1);
    wait_done("t5");
    check(acc_cnt - a0 == 20, "t5_write_count", acc_cnt - a0, 20);

    // randomized rows, invalid indices, full refreshes and slave stalls
    rand_wait = 1'b1;
    repeat (12) begin
      n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++) row_write(5'($urandom_range(0, 23)), 10'($urandom_range(0, 1023)));
      commit($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) begin
        tick();
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) row_write(5'($urandom_range(0, 23)), 10'($urandom_range(0, 1023)));
        commit($urandom_range(0, 3) == 0);
      end
      wait_done("rand");
    end
    rand_wait = 1'b0;
    repeat (2) tick();

    // reset in the middle of the third write abandons the transfer
    a0 = acc_cnt;
    commit(1'b1);
    b = 0;
    while (!(AVM_WRITE && acc_cnt - a0 >= 2) && b < 200) begin
      tick();
      b++;
    end
    check(b < 200, "t6_third_write_seen", b, 200);
    RESET_N = 1'b0;
    tick();
    RESET_N = 1'b1;
    model_reset();
    d0 = done_cnt;
    @(negedge clk);
    check(AVM_WRITE == 1'b0 && AVM_CS == 1'b0, "t6_write_drops", {AVM_CS, AVM_WRITE}, 0);
    check(BUSY == 1'b0, "t6_busy_cleared", BUSY, 0);
    repeat (30) tick();
    check(done_cnt == d0, "t6_no_done_after_reset", done_cnt - d0, 0);
    a0 = acc_cnt;
    commit(1'b0);
    wait_done("t6");
    check(acc_cnt - a0 == 20, "t6_write_count", acc_cnt - a0, 20);

    repeat (5) tick();
    check(done_cnt == exp_done, "final_done_count", done_cnt, exp_done);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
